// File: rtl/rob_commit_pkg.sv
// Shared RS/ROB definitions: ROB geometry, tag widths and the commit FSM states.
package rob_commit_pkg;

  localparam int unsigned ROB_ROW_COUNT = 64;
  localparam int unsigned ROB_IDX_W     = $clog2(ROB_ROW_COUNT);
  localparam int unsigned PREG_TAG_W    = 6;
  localparam int unsigned PC_W          = 32;
  localparam int unsigned RETIRE_CNT_W  = 16;

  // Commit FSM states
  localparam logic [0:0] ST_CHECK     = 1'b0;
  localparam logic [0:0] ST_FREE_WAIT = 1'b1;

endpackage

// File: rtl/rob_commit_unit.sv
// In-order ROB retirement: retires the head row once complete, pulses commit
// and clear, and hands the superseded physical tag to the free list.
module rob_commit_unit
  import rob_commit_pkg::*;
#(
  parameter int unsigned ROB_ROWS = ROB_ROW_COUNT,
  parameter int unsigned PREG_W   = PREG_TAG_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic [ROB_IDX_W-1:0]    rob_head_idx,
  input  logic                    rob_used,
  input  logic                    rob_completed,
  input  logic [PREG_W-1:0]       rob_destreg,
  input  logic [PREG_W-1:0]       rob_old_destreg,
  input  logic [PC_W-1:0]         rob_pc,
  output logic                    rob_clear_en,
  output logic [ROB_IDX_W-1:0]    rob_clear_idx,
  output logic                    commit_valid,
  output logic [PC_W-1:0]         commit_pc,
  output logic [PREG_W-1:0]       commit_destreg,
  output logic                    free_valid,
  output logic [PREG_W-1:0]       free_preg,
  input  logic                    free_ready,
  input  logic                    flush,
  input  logic [ROB_IDX_W-1:0]    flush_head,
  output logic [RETIRE_CNT_W-1:0] retired_count
);

  localparam logic [ROB_IDX_W-1:0] HEAD_MASK = ROB_IDX_W'(ROB_ROWS - 1);

  logic [0:0]              state, state_nxt;
  logic [ROB_IDX_W-1:0]    head, head_nxt;
  logic                    commit_valid_nxt, clear_en_nxt, free_valid_nxt;
  logic [PC_W-1:0]         commit_pc_nxt;
  logic [PREG_W-1:0]       commit_destreg_nxt, free_preg_nxt;
  logic [ROB_IDX_W-1:0]    clear_idx_nxt;
  logic [RETIRE_CNT_W-1:0] count_nxt;

  assign rob_head_idx = head;

  // Next-state and next-output decode
  always_comb begin
    state_nxt          = state;
    head_nxt           = head;
    commit_valid_nxt   = 1'b0;
    commit_pc_nxt      = commit_pc;
    commit_destreg_nxt = commit_destreg;
    clear_en_nxt       = 1'b0;
    clear_idx_nxt      = rob_clear_idx;
    free_valid_nxt     = free_valid;
    free_preg_nxt      = free_preg;
    count_nxt          = retired_count;
    case (state)
      ST_CHECK: begin
        if (flush) begin
          head_nxt = flush_head;
        end else if (rob_used && rob_completed) begin
          commit_valid_nxt   = 1'b1;
          commit_pc_nxt      = rob_pc;
          commit_destreg_nxt = rob_destreg;
          clear_en_nxt       = 1'b1;
          clear_idx_nxt      = head;
          head_nxt           = (head + ROB_IDX_W'(1)) & HEAD_MASK;
          count_nxt          = retired_count + RETIRE_CNT_W'(1);
          // x0 mapping owns no physical register, so nothing to release
          if (rob_old_destreg != '0) begin
            free_valid_nxt = 1'b1;
            free_preg_nxt  = rob_old_destreg;
            state_nxt      = ST_FREE_WAIT;
          end
        end
      end
      ST_FREE_WAIT: begin
        // A flush redirects the head but the pending free is already architectural
        if (flush) head_nxt = flush_head;
        if (free_valid && free_ready) begin
          free_valid_nxt = 1'b0;
          state_nxt      = ST_CHECK;
        end
      end
      default: state_nxt = ST_CHECK;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_CHECK;
      head           <= '0;
      commit_valid   <= 1'b0;
      commit_pc      <= '0;
      commit_destreg <= '0;
      rob_clear_en   <= 1'b0;
      rob_clear_idx  <= '0;
      free_valid     <= 1'b0;
      free_preg      <= '0;
      retired_count  <= '0;
    end else begin
      state          <= state_nxt;
      head           <= head_nxt;
      commit_valid   <= commit_valid_nxt;
      commit_pc      <= commit_pc_nxt;
      commit_destreg <= commit_destreg_nxt;
      rob_clear_en   <= clear_en_nxt;
      rob_clear_idx  <= clear_idx_nxt;
      free_valid     <= free_valid_nxt;
      free_preg      <= free_preg_nxt;
      retired_count  <= count_nxt;
    end
  end

endmodule

// File: tb/tb_rob_commit_unit.sv
// Scoreboard bench for rob_commit_unit: a ROB array model feeds the head row,
// expected commits/frees are queued at issue and checked by a monitor.
module tb_rob_commit_unit;
  import rob_commit_pkg::*;

  localparam int unsigned PW   = 6;
  localparam int unsigned ROWS = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  rob_head_idx;
  logic        rob_used, rob_completed;
  logic [PW-1:0] rob_destreg, rob_old_destreg;
  logic [31:0] rob_pc;
  logic        rob_clear_en;
  logic [5:0]  rob_clear_idx;
  logic        commit_valid;
  logic [31:0] commit_pc;
  logic [PW-1:0] commit_destreg;
  logic        free_valid;
  logic [PW-1:0] free_preg;
  logic        free_ready;
  logic        flush;
  logic [5:0]  flush_head;
  logic [15:0] retired_count;

  rob_commit_unit #(.ROB_ROWS(ROWS), .PREG_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .rob_head_idx(rob_head_idx),
    .rob_used(rob_used), .rob_completed(rob_completed),
    .rob_destreg(rob_destreg), .rob_old_destreg(rob_old_destreg), .rob_pc(rob_pc),
    .rob_clear_en(rob_clear_en), .rob_clear_idx(rob_clear_idx),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_destreg(commit_destreg),
    .free_valid(free_valid), .free_preg(free_preg), .free_ready(free_ready),
    .flush(flush), .flush_head(flush_head), .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  // ROB storage model, read combinationally at the DUT head
  logic          r_used [ROWS];
  logic          r_comp [ROWS];
  logic [31:0]   r_pc   [ROWS];
  logic [PW-1:0] r_dest [ROWS];
  logic [PW-1:0] r_old  [ROWS];

  assign rob_used        = r_used[rob_head_idx];
  assign rob_completed   = r_comp[rob_head_idx];
  assign rob_pc          = r_pc[rob_head_idx];
  assign rob_destreg     = r_dest[rob_head_idx];
  assign rob_old_destreg = r_old[rob_head_idx];

  typedef struct {
    logic [31:0]   pc;
    logic [PW-1:0] dest;
    logic [5:0]    idx;
  } exp_commit_t;

  exp_commit_t   exp_c[$];
  logic [PW-1:0] exp_f[$];
  int            n_vec = 0;
  int            n_err = 0;
  logic [15:0]   mdl_count;
  int            mdl_head;
  int            ready_mode;   // 0 random, 1 held low, 2 held high

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm, input logic [63:0] act);
    n_vec++;
    n_err++;
    $display("FAIL %s: got 0x%0h, expected nothing", nm, act);
  endtask

  // Advance one cycle; retire the row the DUT asked to clear
  task automatic tick();
    @(negedge clk);
    if (rst_n && rob_clear_en) r_used[rob_clear_idx] = 1'b0;
    #1;
  endtask

  task automatic set_row(input int i, input logic u, input logic c, input logic [31:0] pc,
                         input logic [PW-1:0] d, input logic [PW-1:0] o);
    r_used[i] = u; r_comp[i] = c; r_pc[i] = pc; r_dest[i] = d; r_old[i] = o;
  endtask

  // Reference rule: a used row retires in order; non-zero old tag is released
  task automatic expect_retire(input int i);
    exp_commit_t e;
    e.pc = r_pc[i]; e.dest = r_dest[i]; e.idx = 6'(i);
    exp_c.push_back(e);
    if (r_old[i] != '0) exp_f.push_back(r_old[i]);
    mdl_count = mdl_count + 16'd1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < ROWS; i++) set_row(i, 1'b0, 1'b0, 32'd0, '0, '0);
    exp_c.delete();
    exp_f.delete();
    mdl_count = 16'd0;
    mdl_head  = 0;
    tick();
    tick();
  endtask

  // free_ready driver, changes well before the rising edge
  initial begin
    free_ready = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      case (ready_mode)
        1:       free_ready = 1'b0;
        2:       free_ready = 1'b1;
        default: free_ready = ($urandom_range(0, 2) == 0);
      endcase
    end
  end

  // Monitor: pops expected commits/frees when the DUT presents them
  logic prev_fv;
  initial begin
    exp_commit_t e;
    logic [PW-1:0] f;
    prev_fv = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_fv = 1'b0;
      end else begin
        if (prev_fv && free_ready) begin
          check("free_drop_after_handshake", 64'(free_valid), 64'd0);
          if (exp_f.size() == 0) fail_now("unexpected_free_handshake", 64'(free_preg));
          else void'(exp_f.pop_front());
        end else begin
          if (prev_fv) check("free_valid_hold", 64'(free_valid), 64'd1);
          if (free_valid) begin
            if (exp_f.size() == 0) fail_now("unexpected_free", 64'(free_preg));
            else begin
              f = exp_f[0];
              check("free_preg", 64'(free_preg), 64'(f));
            end
          end
        end
        if (commit_valid || rob_clear_en) begin
          check("clear_en_with_commit", 64'(rob_clear_en), 64'(commit_valid));
          if (exp_c.size() == 0) fail_now("unexpected_commit", 64'(commit_pc));
          else begin
            e = exp_c.pop_front();
            check("commit_pc", 64'(commit_pc), 64'(e.pc));
            check("commit_destreg", 64'(commit_destreg), 64'(e.dest));
            check("rob_clear_idx", 64'(rob_clear_idx), 64'(e.idx));
          end
        end
        prev_fv = free_valid;
      end
    end
  end

  initial begin
    int n, base, cyc;
    flush = 1'b0;
    flush_head = 6'd0;
    ready_mode = 1;
    do_reset();

    // Reset values
    check("rst_head", 64'(rob_head_idx), 64'd0);
    check("rst_commit_valid", 64'(commit_valid), 64'd0);
    check("rst_commit_pc", 64'(commit_pc), 64'd0);
    check("rst_commit_destreg", 64'(commit_destreg), 64'd0);
    check("rst_clear_en", 64'(rob_clear_en), 64'd0);
    check("rst_clear_idx", 64'(rob_clear_idx), 64'd0);
    check("rst_free_valid", 64'(free_valid), 64'd0);
    check("rst_free_preg", 64'(free_preg), 64'd0);
    check("rst_retired_count", 64'(retired_count), 64'd0);

    // First retire on first edge, free held off for 5 cycles, row 1 waits
    set_row(0, 1'b1, 1'b1, 32'h100, 6'd12, 6'd5);
    expect_retire(0);
    set_row(1, 1'b1, 1'b1, 32'h104, 6'd13, 6'd0);
    rst_n = 1'b1;
    tick();
    check("t1_commit_valid", 64'(commit_valid), 64'd1);
    check("t1_head", 64'(rob_head_idx), 64'd1);
    check("t1_free_valid", 64'(free_valid), 64'd1);
    check("t1_free_preg", 64'(free_preg), 64'd5);
    check("t1_count", 64'(retired_count), 64'(mdl_count));
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t1_wait_free_valid", 64'(free_valid), 64'd1);
      check("t1_wait_head", 64'(rob_head_idx), 64'd1);
      check("t1_wait_no_commit", 64'(commit_valid), 64'd0);
    end
    ready_mode = 2;
    expect_retire(1);
    tick();
    check("t1_free_dropped", 64'(free_valid), 64'd0);
    check("t1_no_commit_on_drop", 64'(commit_valid), 64'd0);
    tick();
    check("t1_row1_commit", 64'(commit_valid), 64'd1);
    check("t1_row1_head", 64'(rob_head_idx), 64'd2);
    check("t1_row1_count", 64'(retired_count), 64'(mdl_count));

    // Four back-to-back retires without frees
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_row(i, 1'b1, 1'b1, 32'h200 + 32'(4 * i), 6'(20 + i), 6'd0);
      expect_retire(i);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t2_commit_pulse", 64'(commit_valid), 64'd1);
      check("t2_head_step", 64'(rob_head_idx), 64'(i + 1));
    end
    tick();
    check("t2_commit_end", 64'(commit_valid), 64'd0);
    check("t2_head", 64'(rob_head_idx), 64'd4);
    check("t2_count", 64'(retired_count), 64'd4);

    // Head wrap from row 63 (reached by flush)
    ready_mode = 2;
    set_row(63, 1'b1, 1'b1, 32'h3f0, 6'd7, 6'd9);
    flush = 1'b1; flush_head = 6'd63;
    tick();
    flush = 1'b0;
    check("t3_flush_head", 64'(rob_head_idx), 64'd63);
    check("t3_flush_no_commit", 64'(commit_valid), 64'd0);
    expect_retire(63);
    tick();
    check("t3_wrap_commit", 64'(commit_valid), 64'd1);
    check("t3_wrap_head", 64'(rob_head_idx), 64'd0);
    check("t3_wrap_free_preg", 64'(free_preg), 64'd9);
    tick();
    check("t3_free_done", 64'(free_valid), 64'd0);

    // Flush suppresses a ready retire
    set_row(0, 1'b1, 1'b1, 32'h300, 6'd4, 6'd3);
    flush = 1'b1; flush_head = 6'd20;
    tick();
    flush = 1'b0;
    r_used[0] = 1'b0;
    check("t4_flush_no_commit", 64'(commit_valid), 64'd0);
    check("t4_flush_head", 64'(rob_head_idx), 64'd20);
    check("t4_flush_count", 64'(retired_count), 64'(mdl_count));

    // Flush during FREE_WAIT keeps the pending free
    ready_mode = 1;
    set_row(20, 1'b1, 1'b1, 32'h400, 6'd21, 6'd11);
    expect_retire(20);
    tick();
    check("t4_fw_head", 64'(rob_head_idx), 64'd21);
    check("t4_fw_free_valid", 64'(free_valid), 64'd1);
    flush = 1'b1; flush_head = 6'd40;
    tick();
    flush = 1'b0;
    check("t4_fw_flush_head", 64'(rob_head_idx), 64'd40);
    check("t4_fw_free_kept", 64'(free_valid), 64'd1);
    check("t4_fw_free_preg", 64'(free_preg), 64'd11);
    ready_mode = 2;
    tick();
    check("t4_fw_free_delivered", 64'(free_valid), 64'd0);
    check("t4_fw_count", 64'(retired_count), 64'(mdl_count));

    // Asynchronous reset during FREE_WAIT drops the pending free
    ready_mode = 1;
    set_row(40, 1'b1, 1'b1, 32'h500, 6'd30, 6'd14);
    expect_retire(40);
    tick();
    check("t5_fw_entered", 64'(free_valid), 64'd1);
    check("t5_head", 64'(rob_head_idx), 64'd41);
    rst_n = 1'b0;
    #1;
    check("t5_async_free_valid", 64'(free_valid), 64'd0);
    check("t5_async_head", 64'(rob_head_idx), 64'd0);
    check("t5_async_count", 64'(retired_count), 64'd0);
    check("t5_async_commit", 64'(commit_valid), 64'd0);
    do_reset();
    rst_n = 1'b1;

    // Randomized batches with staggered completion and random free_ready
    ready_mode = 0;
    for (int b = 0; b < 40; b++) begin
      n = int'($urandom_range(1, 12));
      base = mdl_head;
      for (int k = 0; k < n; k++) begin
        set_row((base + k) % ROWS, 1'b1, 1'($urandom), $urandom, 6'($urandom),
                ($urandom_range(0, 2) == 0) ? 6'd0 : 6'($urandom));
        expect_retire((base + k) % ROWS);
      end
      mdl_head = (base + n) % ROWS;
      cyc = 0;
      while ((exp_c.size() != 0 || exp_f.size() != 0) && cyc < 400) begin
        r_comp[(base + int'($urandom_range(0, n - 1))) % ROWS] = 1'b1;
        tick();
        cyc++;
      end
      if (cyc >= 400) fail_now("batch_timeout", 64'(exp_c.size()));
      tick();
      tick();
      check("rand_head", 64'(rob_head_idx), 64'(mdl_head));
      check("rand_count", 64'(retired_count), 64'(mdl_count));
      check("rand_free_idle", 64'(free_valid), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rob_commit_unit.md
ROB_COMMIT_UNIT -- requirements
Module: rob_commit_unit

Interface
REQ-001 The block SHALL expose parameter ROB_ROWS, default 64, meaning ROB entry count (power of two).
REQ-002 The block SHALL expose parameter PREG_W, default 6, meaning physical register tag width.
REQ-003 Port clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port rob_head_idx  output  6  ROB row index being examined (read address).
REQ-006 Port rob_used, rob_completed  input  1 each  used/completed bits of row rob_head_idx (combinational read).
REQ-007 Port rob_destreg, rob_old_destreg  input  PREG_W each  new/previous physical tags of that row.
REQ-008 Port rob_pc  input  32  PC of that row.
REQ-009 Port rob_clear_en / rob_clear_idx  output  1 / 6  one-cycle request to clear used bit of row rob_clear_idx.
REQ-010 Port commit_valid  output  1  one-cycle commit pulse; commit_pc output 32, commit_destreg output PREG_W qualify it.
REQ-011 Port free_valid / free_preg  output  1 / PREG_W  released physical tag to the free list; free_ready input 1 accepts it.
REQ-012 Port flush / flush_head  input  1 / 6  synchronous pipeline flush; new head index.
REQ-013 Port retired_count  output  16  total retirements since reset, wraps at 65535->0.

Function
REQ-014 FSM states SHALL be CHECK and FREE_WAIT only.
REQ-015 In CHECK, when rob_used=1 and rob_completed=1 and flush=0, the unit SHALL retire the head row: next cycle commit_valid=1 with commit_pc=rob_pc, commit_destreg=rob_destreg, rob_clear_en=1 with rob_clear_idx=old head.
REQ-016 On retire, head SHALL increment by one, wrapping ROB_ROWS-1 -> 0, and retired_count SHALL increment.
REQ-017 On retire with rob_old_destreg != 0, free_preg SHALL capture rob_old_destreg, free_valid SHALL assert next cycle, and state SHALL go FREE_WAIT; with rob_old_destreg = 0 (x0 mapping) no free SHALL occur and state SHALL stay CHECK.
REQ-018 In CHECK with rob_used=0 (empty) or rob_completed=0 (head not done), nothing SHALL retire and all pulses SHALL be 0.
REQ-019 Throughput: back-to-back retires without frees SHALL sustain one per cycle; commit_valid and rob_clear_en SHALL each be high exactly one cycle per retire.
REQ-020 In FREE_WAIT, free_valid and free_preg SHALL hold stable until the cycle free_valid=1 and free_ready=1; the following cycle free_valid=0 and state=CHECK; no retire SHALL start in FREE_WAIT.
REQ-021 flush=1 in CHECK SHALL suppress any retire that cycle and load head with flush_head.
REQ-022 flush=1 in FREE_WAIT SHALL load head with flush_head but SHALL NOT drop the pending free (already architectural); handshake completes normally.
REQ-023 rob_head_idx SHALL equal the registered head pointer (no combinational path from inputs).

Reset
REQ-024 While rst_n=0: head=0, state=CHECK, commit_valid=0, commit_pc=0, commit_destreg=0, rob_clear_en=0, rob_clear_idx=0, free_valid=0, free_preg=0, retired_count=0.
REQ-025 Reset asserted mid-FREE_WAIT SHALL discard the pending free immediately (asynchronous).
REQ-026 First retire after rst_n deasserts SHALL be possible on the first rising edge.

Structure
REQ-027 ROB_ROW_COUNT, ROB index width, PREG_W and the CHECK/FREE_WAIT state enum SHALL live in the shared RS/ROB struct package.
REQ-028 The design SHALL be a single module; no sub-module is required.

Verification
REQ-029 Row 0 {used=1, completed=1, pc=0x100, destreg=12, old=5} after reset -> next cycle commit_valid=1, commit_pc=0x100, commit_destreg=12, rob_clear_idx=0, free_valid=1, free_preg=5, head=1.
REQ-030 Rows 0-3 completed, all old_destreg=0 -> four consecutive commit_valid pulses, head=4, retired_count=4, free_valid never 1.
REQ-031 free_ready held 0 for 5 cycles after a free -> free_valid/free_preg stable 5 cycles, no commit, head unchanged; free_ready=1 -> free_valid drops next cycle.
REQ-032 Head=63 completed, old=9 -> commit, head wraps to 0, free_preg=9.
REQ-033 flush=1 flush_head=20 while head completed -> no commit that cycle, head=20; flush during FREE_WAIT -> free still delivered.
REQ-034 rst_n pulsed low during FREE_WAIT -> free_valid=0 asynchronously, head=0, retired_count=0.
